// File: rtl/inst_cache_if_pkg.sv
// Shared types and helpers for the instruction cache front end.
// Optional feature macro used by this slice: ICACHE_PERF_EN (hit/miss counters).
package inst_cache_if_pkg;

  localparam int ICACHE_DATA_W = 32;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_REQ  = 1'b1
  } icache_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_cache_if_line_store.sv
// Tag/data/valid storage: asynchronous read, synchronous write, flush-all.
// Only the valid bits are reset; flush wins over a same-cycle write.
module icache_line_store
  import inst_cache_if_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 26,
  parameter int DATA_W    = ICACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_flush
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_W-1:0]    r_data [NUM_LINES];

  // Valid bits: cleared by reset or flush, set by a fill write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_cache_if.sv
// Direct-mapped, one-word-per-line instruction cache for the core fetch port.
// Hits answer in the fetch cycle; misses stall and run a single req/ack fill.
// Define ICACHE_PERF_EN to add saturating hit/miss counters and their ports.
module inst_cache_if
  import inst_cache_if_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  icache_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_fill_start, w_fill_done;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [31:0]       w_rd_data;
  logic              w_hit, w_miss;

  assign w_idx = rom_addr_i[IDX_W+1:2];
  assign w_tag = rom_addr_i[ADDR_W-1:IDX_W+2];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .DATA_W    (32)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill_done),
    .i_wr_idx   (r_mem_addr[IDX_W+1:2]),
    .i_wr_tag   (r_mem_addr[ADDR_W-1:IDX_W+2]),
    .i_wr_data  (mem_rdata_i),
    .i_flush    (flush_i)
  );

  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
  assign w_miss     = rom_ce_i && !w_hit;
  assign stallreq_o = w_miss;
  assign rom_data_o = (rom_ce_i && w_hit) ? w_rd_data : 32'd0;

  // mem_req_o is decoded from state so reset drops it without waiting for a clock.
  assign mem_req_o  = (r_state == ICACHE_REQ);
  assign mem_addr_o = r_mem_addr;

  // State register and fill address latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ICACHE_IDLE;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fill_start)
        r_mem_addr <= rom_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
    end
  end

  // Next state: start a fill on a miss in IDLE, finish it on ack in REQ.
  always_comb begin
    w_state_nxt  = r_state;
    w_fill_start = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      ICACHE_IDLE: begin
        if (w_miss) begin
          w_state_nxt  = ICACHE_REQ;
          w_fill_start = 1'b1;
        end
      end
      ICACHE_REQ: begin
        if (mem_ack_i) begin
          w_state_nxt = ICACHE_IDLE;
          w_fill_done = 1'b1;
        end
      end
      default: w_state_nxt = ICACHE_IDLE;
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Saturating performance counters; a hit in a flush cycle is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (rom_ce_i && w_hit && !flush_i) r_hit_cnt  <= sat_inc32(r_hit_cnt);
      if (w_fill_start)                  r_miss_cnt <= sat_inc32(r_miss_cnt);
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_inst_cache_if.sv
// Scoreboard bench for inst_cache_if: stimulus queues expected fetch data and
// fill addresses, a monitor compares whenever the DUT completes a fetch or
// raises a fill request. A simple memory model acks fills after ack_dly cycles.
module tb_inst_cache_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  inst_cache_if dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .stallreq_o  (stallreq_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] q_data [$];
  logic [31:0] q_fill [$];
  int          fills = 0;
  int          req_cycles = 0;
  int          ack_dly = 2;
  bit          flush_next_ack = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] cur_fill = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h3401_0001 : (32'hC0DE_0000 | a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=none required=event", name);
  endtask

  // Monitor: pops expected data on each completed fetch, expected address on each new fill.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rom_ce_i && !stallreq_o) begin
          if (q_data.size() == 0) fail_now("unexpected_fetch");
          else chk("rom_data", rom_data_o, q_data.pop_front());
        end else if (rom_ce_i) begin
          chk("data_in_stall", rom_data_o, 32'd0);
        end else begin
          chk("idle_data", rom_data_o, 32'd0);
          chk("idle_stall", {31'd0, stallreq_o}, 32'd0);
        end
        if (mem_req_o) req_cycles++;
        if (mem_req_o && !prev_req) begin
          fills++;
          cur_fill = mem_addr_o;
          if (q_fill.size() == 0) fail_now("unexpected_fill");
          else chk("fill_addr", mem_addr_o, q_fill.pop_front());
        end else if (mem_req_o) begin
          chk("fill_addr_stable", mem_addr_o, cur_fill);
        end
      end
      prev_req = mem_req_o;
    end
  end

  // Memory model: ack the ack_dly-th cycle of a request, optionally with a flush pulse.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'd0;
    flush_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      flush_i = 1'b0;
      if (rst || !mem_req_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == ack_dly) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          if (flush_next_ack) begin
            flush_i = 1'b1;
            flush_next_ack = 1'b0;
          end
          cnt = 0;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int exp_stall, input int n_fill);
    int  stalls;
    bit  done;
    q_data.push_back(mem_word(a));
    for (int k = 0; k < n_fill; k++) q_fill.push_back(a & 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    rom_ce_i = 1'b1;
    rom_addr_i = a;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!stallreq_o) done = 1'b1;
      else stalls++;
    end
    if (!done) fail_now("fetch_timeout");
    else chk("stall_cycles", stalls, exp_stall);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    rom_ce_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  r0;
    int  f0;
    bit  seen;
    rom_addr_i = 32'd0;
    do_reset(3);

    // Reset state (checked by rolling back into reset briefly after the first release).
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_data", rom_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold miss, ack on the third request cycle.
    ack_dly = 3;
    r0 = req_cycles;
    fetch(32'h0000_0000, 4, 1);
    chk("t1_req_cycles", req_cycles - r0, 3);

    // Fill remaining 15 lines at minimum penalty, then re-fetch all 16 with no traffic.
    ack_dly = 1;
    for (int i = 1; i < 16; i++) fetch(i * 4, 2, 1);
    f0 = fills;
    r0 = req_cycles;
    for (int i = 0; i < 16; i++) fetch(i * 4, 0, 0);
    chk("t2_no_fills", fills - f0, 0);
    chk("t2_no_req", req_cycles - r0, 0);

    // Conflict on index 1.
    ack_dly = 2;
    fetch(32'h0000_0044, 3, 1);
    fetch(32'h0000_0004, 3, 1);

    // Flush collides with ack: 0x08 is refilled a second time, other lines are gone too.
    fetch(32'h0000_0048, 3, 1);
    flush_next_ack = 1'b1;
    fetch(32'h0000_0008, 6, 2);
    fetch(32'h0000_000C, 3, 1);

    // Reset in the middle of a fill.
    ack_dly = 10;
    q_fill.push_back(32'h0000_0100);
    @(posedge clk);
    #1;
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_0100;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_req_o) seen = 1'b1;
    end
    if (!seen) fail_now("t5_req_never_rose");
    @(negedge clk);
    rst = 1'b1;
    rom_ce_i = 1'b0;
    #1;
    chk("t5_req_async_drop", {31'd0, mem_req_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_dly = 2;
    fetch(32'h0000_0000, 3, 1);

`ifdef ICACHE_PERF_EN
    @(posedge clk);
    #1;
    do_reset(2);
    ack_dly = 1;
    for (int i = 0; i < 16; i++) fetch(i * 4, 2, 1);
    for (int i = 0; i < 16; i++) fetch(i * 4, 0, 0);
    @(posedge clk);
    #1;
    rom_ce_i = 1'b0;
    @(negedge clk);
    chk("perf_miss_cnt", miss_cnt_o, 32'd16);
    chk("perf_hit_cnt", hit_cnt_o, 32'd32);
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.r_hit_cnt;
    for (int i = 0; i < 3; i++) fetch(i * 4, 0, 0);
    @(posedge clk);
    #1;
    rom_ce_i = 1'b0;
    @(negedge clk);
    chk("perf_hit_sat", hit_cnt_o, 32'hFFFF_FFFF);
`endif

    @(posedge clk);
    #1;
    rom_ce_i = 1'b0;
    repeat (2) @(posedge clk);
    if (q_data.size() != 0) fail_now("leftover_expected_data");
    if (q_fill.size() != 0) fail_now("leftover_expected_fill");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
